up_param: RTL and testbench

Parametrised accumulator microprocessor core. It is the next generation of the team's 4-bit two-phase processor: data width and address width are configurable, and it adds a hardware call/return stack, a HALT state and a 3-cycle memory-read path. Program ROM and data RAM sit outside the core on plain synchronous ports, so the core can be reused with any memory size and benched without internal memories. It sits between the program ROM, the data RAM, the pushbutton input and the LED/FF output register.

---
 rtl/up_param_if.sv | 36 +++
 rtl/up_param.sv | 219 +++++++++++++++++++++
 tb/tb_up_param.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/up_param_if.sv
// Core-side bus bundle: program ROM, data RAM, I/O and status outputs.
interface up_param_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 12
);
  logic [ADDR_W-1:0]   prog_addr;
  logic [4+ADDR_W-1:0] prog_data;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_rdata;
  logic [DATA_W-1:0]   in_port;
  logic [DATA_W-1:0]   out_port;
  logic                out_valid;
  logic [1:0]          phase;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   accu;
  logic                c_flag;
  logic                z_flag;
  logic                halted;
  logic                stack_err;

  // Core drives addresses, strobes and status
  modport master (
    output prog_addr, ram_addr, ram_wdata, ram_we, out_port, out_valid,
           phase, pc, accu, c_flag, z_flag, halted, stack_err,
    input  prog_data, ram_rdata, in_port
  );

  // Memories / board drive instruction, read data and pushbuttons
  modport slave (
    input  prog_addr, ram_addr, ram_wdata, ram_we, out_port, out_valid,
           phase, pc, accu, c_flag, z_flag, halted, stack_err,
    output prog_data, ram_rdata, in_port
  );
endinterface

// File: rtl/up_param.sv
// Parametrised accumulator core: FETCH/EXEC/MEMRD/HALT sequencer with call stack.
module up_param #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned STACK_DEPTH = 4
) (
  input logic       clock,
  input logic       reset,
  up_param_if.master bus
);
  localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IR_W = 4 + ADDR_W;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LDI   = 4'd1;
  localparam logic [3:0] OP_LD    = 4'd2;
  localparam logic [3:0] OP_ST    = 4'd3;
  localparam logic [3:0] OP_ADDI  = 4'd4;
  localparam logic [3:0] OP_OUT   = 4'd5;
  localparam logic [3:0] OP_SUBI  = 4'd6;
  localparam logic [3:0] OP_NANDI = 4'd7;
  localparam logic [3:0] OP_CMPI  = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JC    = 4'd10;
  localparam logic [3:0] OP_JNZ   = 4'd11;
  localparam logic [3:0] OP_CALL  = 4'd12;
  localparam logic [3:0] OP_RET   = 4'd13;
  localparam logic [3:0] OP_IN    = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEMRD = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   accu_q, accu_d;
  logic                c_q, c_d, z_q, z_d;
  logic [IR_W-1:0]     ir_q, ir_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                ram_we_q, ram_we_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic                stack_err_q, stack_err_d;
  logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0]   stack_d [STACK_DEPTH];

  logic [3:0]          op;
  logic [ADDR_W-1:0]   field;
  logic [DATA_W-1:0]   imm;
  logic [3:0]          fetch_op;
  logic [ADDR_W-1:0]   pc_inc;
  logic [DATA_W:0]     add_sum;
  logic [DATA_W:0]     sub_sum;
  logic [ADDR_W-1:0]   pop_val;

  assign op       = ir_q[IR_W-1 -: 4];
  assign field    = ir_q[ADDR_W-1:0];
  assign imm      = field[DATA_W-1:0];
  assign fetch_op = bus.prog_data[IR_W-1 -: 4];
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign add_sum  = {1'b0, accu_q} + {1'b0, imm};
  assign sub_sum  = {1'b0, accu_q} + {1'b0, ~imm} + (DATA_W + 1)'(1);

  // Top-of-stack read for RET
  always_comb begin
    pop_val = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) pop_val = stack_q[i];
    end
  end

  // Next-state and datapath decode
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    accu_d      = accu_q;
    c_d         = c_q;
    z_d         = z_q;
    ir_d        = ir_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    ram_we_d    = 1'b0;
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    stack_d     = stack_q;

    unique case (state_q)
      S_FETCH: begin
        ir_d    = bus.prog_data;
        state_d = S_EXEC;
        // Strobes are registered here so they are high for exactly the EXEC cycle
        ram_we_d = (fetch_op == OP_ST);
        if (fetch_op == OP_OUT) begin
          out_valid_d = 1'b1;
          out_d       = accu_q;
        end
      end
      S_EXEC: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
        unique case (op)
          OP_NOP, OP_ST, OP_OUT: ;
          OP_LDI: begin
            accu_d = imm;
            z_d    = (imm == '0);
          end
          OP_LD: state_d = S_MEMRD;
          OP_ADDI: begin
            {c_d, accu_d} = add_sum;
            z_d           = (add_sum[DATA_W-1:0] == '0);
          end
          OP_SUBI: begin
            {c_d, accu_d} = sub_sum;
            z_d           = (sub_sum[DATA_W-1:0] == '0);
          end
          OP_NANDI: begin
            accu_d = ~(accu_q & imm);
            z_d    = ((accu_q & imm) == {DATA_W{1'b1}});
          end
          OP_CMPI: begin
            c_d = sub_sum[DATA_W];
            z_d = (sub_sum[DATA_W-1:0] == '0);
          end
          OP_JMP: pc_d = field;
          OP_JC:  if (c_q) pc_d = field;
          OP_JNZ: if (!z_q) pc_d = field;
          OP_CALL: begin
            if (sp_q == SP_W'(STACK_DEPTH)) begin
              pc_d        = pc_q;
              stack_err_d = 1'b1;
              state_d     = S_HALT;
            end else begin
              for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                if (sp_q == SP_W'(i)) stack_d[i] = pc_inc;
              end
              sp_d = sp_q + SP_W'(1);
              pc_d = field;
            end
          end
          OP_RET: begin
            if (sp_q == '0) begin
              pc_d        = pc_q;
              stack_err_d = 1'b1;
              state_d     = S_HALT;
            end else begin
              sp_d = sp_q - SP_W'(1);
              pc_d = pop_val;
            end
          end
          OP_IN: begin
            accu_d = bus.in_port;
            z_d    = (bus.in_port == '0);
          end
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
      S_MEMRD: begin
        accu_d  = bus.ram_rdata;
        z_d     = (bus.ram_rdata == '0);
        state_d = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      accu_q      <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      ir_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ram_we_q    <= 1'b0;
      sp_q        <= '0;
      stack_err_q <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      accu_q      <= accu_d;
      c_q         <= c_d;
      z_q         <= z_d;
      ir_q        <= ir_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ram_we_q    <= ram_we_d;
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
      stack_q     <= stack_d;
    end
  end

  assign bus.prog_addr = pc_q;
  assign bus.ram_addr  = field;
  assign bus.ram_wdata = accu_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.out_port  = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.phase     = state_q;
  assign bus.pc        = pc_q;
  assign bus.accu      = accu_q;
  assign bus.c_flag    = c_q;
  assign bus.z_flag    = z_q;
  assign bus.halted    = (state_q == S_HALT);
  assign bus.stack_err = stack_err_q;
endmodule

// File: tb/tb_up_param.sv
// Self-checking bench for up_param: ROM/RAM models plus write/output scoreboards.
module tb_up_param;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 12;

  localparam logic [3:0] NOP = 4'd0, LDI = 4'd1, LD = 4'd2, ST = 4'd3,
                         ADDI = 4'd4, OUT = 4'd5, SUBI = 4'd6, NANDI = 4'd7,
                         CMPI = 4'd8, JMP = 4'd9, JC = 4'd10, JNZ = 4'd11,
                         CALL = 4'd12, RET = 4'd13, IN = 4'd14, HLT = 4'd15;

  logic clock;
  logic reset;
  up_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  up_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STACK_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0]       rom [4096];
  logic [DATA_W-1:0] ram [4096];
  logic [DATA_W-1:0] rdata_q;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [15:0] exp_wr [$];
  logic [3:0]  exp_out [$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign bus.prog_data = rom[bus.prog_addr];
  assign bus.ram_rdata = rdata_q;

  always @(posedge clock) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    rdata_q <= ram[bus.ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] f);
    return {op, f};
  endfunction

  // Scoreboard consumers: every strobe must match the next expected event
  always @(negedge clock) begin
    if (bus.ram_we) begin
      if (exp_wr.size() == 0) check("ram_we_unexpected", 32'(bus.ram_we), 32'd0);
      else check("ram_wr", 32'({bus.ram_addr, bus.ram_wdata}), 32'(exp_wr.pop_front()));
    end
    if (bus.out_valid) begin
      if (exp_out.size() == 0) check("out_valid_unexpected", 32'(bus.out_valid), 32'd0);
      else check("out_port", 32'(bus.out_port), 32'(exp_out.pop_front()));
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = ins(NOP, 12'h000);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
  endtask

  task automatic drained(input string tag);
    check({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    check({tag, "_out_left"}, 32'(exp_out.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_port = '0;
    for (int i = 0; i < 4096; i++) ram[i] = '0;

    // LDI/ADDI carry and reset values
    clear_rom();
    rom[0] = ins(LDI, 12'h005);
    rom[1] = ins(ADDI, 12'h00C);
    rom[2] = ins(HLT, 12'h000);
    do_reset();
    check("rst_pc", 32'(bus.pc), 32'h0);
    check("rst_accu", 32'(bus.accu), 32'h0);
    check("rst_flags", 32'({bus.c_flag, bus.z_flag}), 32'h0);
    check("rst_phase", 32'(bus.phase), 32'h0);
    check("rst_strobes", 32'({bus.ram_we, bus.out_valid, bus.halted, bus.stack_err}), 32'h0);
    check("rst_out", 32'(bus.out_port), 32'h0);
    run(4);
    check("addi_accu", 32'(bus.accu), 32'h1);
    check("addi_cz", 32'({bus.c_flag, bus.z_flag}), 32'b10);
    check("addi_pc", 32'(bus.pc), 32'h2);
    run(2);
    check("halt_state", 32'({bus.halted, bus.phase}), 32'b111);
    run(3);
    check("halt_hold", 32'({bus.halted, bus.phase, bus.accu}), 32'b111_0001);

    // ST then LD round trip, then OUT of the loaded value
    clear_rom();
    rom[0] = ins(LDI, 12'h009);
    rom[1] = ins(ST, 12'h010);
    rom[2] = ins(LDI, 12'h000);
    rom[3] = ins(LD, 12'h010);
    rom[4] = ins(OUT, 12'h000);
    rom[5] = ins(HLT, 12'h000);
    exp_wr.push_back({12'h010, 4'h9});
    exp_out.push_back(4'h9);
    do_reset();
    run(6);
    check("ldi0_z", 32'({bus.accu, bus.z_flag}), 32'b0000_1);
    run(2);
    check("ld_memrd", 32'(bus.phase), 32'h2);
    run(1);
    check("ld_accu", 32'(bus.accu), 32'h9);
    check("ld_z", 32'(bus.z_flag), 32'h0);
    check("ld_pc", 32'(bus.pc), 32'h4);
    run(4);
    drained("st_ld");

    // CMPI equal / less, JNZ not taken / taken
    clear_rom();
    rom[0] = ins(LDI, 12'h003);
    rom[1] = ins(CMPI, 12'h003);
    rom[2] = ins(JNZ, 12'h100);
    rom[3] = ins(LDI, 12'h002);
    rom[4] = ins(CMPI, 12'h003);
    rom[5] = ins(JNZ, 12'h100);
    rom[12'h100] = ins(HLT, 12'h000);
    do_reset();
    run(4);
    check("cmpi_eq_cz", 32'({bus.c_flag, bus.z_flag}), 32'b11);
    check("cmpi_eq_accu", 32'(bus.accu), 32'h3);
    run(2);
    check("jnz_not_taken", 32'(bus.pc), 32'h3);
    run(4);
    check("cmpi_lt_cz", 32'({bus.c_flag, bus.z_flag}), 32'b00);
    run(2);
    check("jnz_taken", 32'(bus.pc), 32'h100);

    // NANDI, SUBI borrow, JC not taken / taken
    clear_rom();
    rom[0] = ins(LDI, 12'h00F);
    rom[1] = ins(NANDI, 12'h003);
    rom[2] = ins(SUBI, 12'h00D);
    rom[3] = ins(JC, 12'h300);
    rom[4] = ins(ADDI, 12'h001);
    rom[5] = ins(JC, 12'h300);
    do_reset();
    run(4);
    check("nandi", 32'({bus.accu, bus.z_flag}), 32'b1100_0);
    run(2);
    check("subi_borrow", 32'({bus.c_flag, bus.accu}), 32'b0_1111);
    run(2);
    check("jc_not_taken", 32'(bus.pc), 32'h4);
    run(2);
    check("addi_wrap", 32'({bus.c_flag, bus.z_flag, bus.accu}), 32'b11_0000);
    run(2);
    check("jc_taken", 32'(bus.pc), 32'h300);

    // Nested calls to depth 4, returns, then RET underflow
    clear_rom();
    rom[0]      = ins(CALL, 12'h010);
    rom[12'h10] = ins(CALL, 12'h020);
    rom[12'h20] = ins(CALL, 12'h030);
    rom[12'h30] = ins(CALL, 12'h040);
    rom[12'h40] = ins(RET, 12'h000);
    rom[12'h31] = ins(RET, 12'h000);
    rom[12'h21] = ins(RET, 12'h000);
    rom[12'h11] = ins(RET, 12'h000);
    rom[1]      = ins(RET, 12'h000);
    do_reset();
    run(8);
    check("call4_pc", 32'(bus.pc), 32'h040);
    run(2);
    check("ret1_pc", 32'(bus.pc), 32'h031);
    run(2);
    check("ret2_pc", 32'(bus.pc), 32'h021);
    run(2);
    check("ret3_pc", 32'(bus.pc), 32'h011);
    run(2);
    check("ret4_pc", 32'(bus.pc), 32'h001);
    check("ret4_err", 32'(bus.stack_err), 32'h0);
    run(2);
    check("underflow", 32'({bus.stack_err, bus.halted, bus.phase}), 32'b1111);
    check("underflow_pc", 32'(bus.pc), 32'h001);

    // Fifth CALL overflows
    clear_rom();
    rom[0]      = ins(CALL, 12'h010);
    rom[12'h10] = ins(CALL, 12'h020);
    rom[12'h20] = ins(CALL, 12'h030);
    rom[12'h30] = ins(CALL, 12'h040);
    rom[12'h40] = ins(CALL, 12'h050);
    do_reset();
    run(10);
    check("overflow", 32'({bus.stack_err, bus.halted, bus.phase}), 32'b1111);
    check("overflow_pc", 32'(bus.pc), 32'h040);
    run(4);
    check("overflow_hold", 32'({bus.pc, bus.phase}), 32'({12'h040, 2'd3}));

    // IN sampled on EXEC, OUT pulses once
    clear_rom();
    rom[0] = ins(IN, 12'h000);
    rom[1] = ins(OUT, 12'h000);
    rom[2] = ins(HLT, 12'h000);
    exp_out.push_back(4'hA);
    do_reset();
    bus.in_port = 4'hA;
    run(2);
    bus.in_port = 4'h3;
    check("in_accu", 32'({bus.accu, bus.z_flag}), 32'b1010_0);
    run(6);
    drained("in_out");

    // Reset during MEMRD aborts the load
    clear_rom();
    ram[12'h021] = 4'h5;
    rom[0] = ins(LDI, 12'h007);
    rom[1] = ins(LD, 12'h021);
    do_reset();
    run(4);
    check("abort_in_memrd", 32'(bus.phase), 32'h2);
    reset = 1'b1;
    run(1);
    check("abort_accu", 32'(bus.accu), 32'h0);
    check("abort_pc_phase", 32'({bus.pc, bus.phase}), 32'h0);
    check("abort_flags", 32'({bus.c_flag, bus.z_flag, bus.ram_we}), 32'h0);

    // pc wraps at the top of the address space
    clear_rom();
    rom[0]        = ins(JMP, 12'hFFF);
    rom[12'hFFF]  = ins(NOP, 12'h000);
    do_reset();
    run(2);
    check("jmp_top", 32'(bus.pc), 32'hFFF);
    run(2);
    check("pc_wrap", 32'(bus.pc), 32'h000);
    drained("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
